// File: rtl/exec_stage.sv
// exec_stage: RV32 R-type execute stage presenting a held register-file write request.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (MUL, func7=0000001).
module exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_we,
    output logic             out_illegal,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef EXEC_MUL_EN
        ST_MUL  = 2'd1,
`endif
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [4:0]       out_rd_r, out_rd_s;
    logic [WIDTH-1:0] out_data_r, out_data_s;
    logic             out_we_r, out_we_s;
    logic             out_illegal_r, out_illegal_s;

    logic [6:0]       opcode_s;
    logic [2:0]       func3_s;
    logic [6:0]       func7_s;
    logic [4:0]       rd_s;
    logic [SHW-1:0]   shamt_s;
    logic             legal_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             accept_s;
    logic             unused_s;

`ifdef EXEC_MUL_EN
    localparam int CW = SHW + 1;
    logic             is_mul_s;
    logic [WIDTH-1:0] mcand_r, mcand_s;
    logic [WIDTH-1:0] mplier_r, mplier_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] acc_step_s;
    logic [CW-1:0]    cnt_r, cnt_s;

    assign acc_step_s = acc_r + (mplier_r[0] ? mcand_r : '0);
`endif

    assign opcode_s = instruction[6:0];
    assign rd_s     = instruction[11:7];
    assign func3_s  = instruction[14:12];
    assign func7_s  = instruction[31:25];
    assign shamt_s  = rs2_data[SHW-1:0];
    // Register indices are resolved upstream; only the operand values arrive here.
    assign unused_s = ^instruction[24:15];

    assign in_ready    = !reset && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready));
    assign accept_s    = in_valid && in_ready;
    assign out_valid   = (state_r == ST_DONE);
    assign busy        = (state_r != ST_IDLE);
    assign out_rd      = out_rd_r;
    assign out_data    = out_data_r;
    assign out_we      = out_we_r;
    assign out_illegal = out_illegal_r;

    // Instruction decode and single-cycle ALU
    always_comb begin
        legal_s   = 1'b0;
        alu_res_s = '0;
`ifdef EXEC_MUL_EN
        is_mul_s  = 1'b0;
`endif
        if (opcode_s == 7'b0110011) begin
            legal_s = 1'b1;
            case ({func7_s, func3_s})
                10'b0000000_000: alu_res_s = rs1_data + rs2_data;
                10'b0100000_000: alu_res_s = rs1_data - rs2_data;
                10'b0000000_001: alu_res_s = rs1_data << shamt_s;
                10'b0000000_010: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(rs1_data) < $signed(rs2_data))};
                10'b0000000_011: alu_res_s = {{(WIDTH-1){1'b0}}, (rs1_data < rs2_data)};
                10'b0000000_100: alu_res_s = rs1_data ^ rs2_data;
                10'b0000000_101: alu_res_s = rs1_data >> shamt_s;
                10'b0100000_101: alu_res_s = $signed(rs1_data) >>> shamt_s;
                10'b0000000_110: alu_res_s = rs1_data | rs2_data;
                10'b0000000_111: alu_res_s = rs1_data & rs2_data;
`ifdef EXEC_MUL_EN
                10'b0000001_000: is_mul_s = 1'b1;
`endif
                default:         legal_s = 1'b0;
            endcase
        end else begin
            legal_s = 1'b0;
        end
    end

    // Next-state and next-result logic; an accept in DONE overrides the return to IDLE
    always_comb begin
        state_s       = state_r;
        out_rd_s      = out_rd_r;
        out_data_s    = out_data_r;
        out_we_s      = out_we_r;
        out_illegal_s = out_illegal_r;
`ifdef EXEC_MUL_EN
        mcand_s       = mcand_r;
        mplier_s      = mplier_r;
        acc_s         = acc_r;
        cnt_s         = cnt_r;
`endif
        if (accept_s) begin
            out_rd_s      = rd_s;
            out_illegal_s = !legal_s;
            out_we_s      = legal_s && (rd_s != 5'd0);
            out_data_s    = legal_s ? alu_res_s : '0;
            state_s       = ST_DONE;
`ifdef EXEC_MUL_EN
            if (is_mul_s) begin
                mcand_s  = rs1_data;
                mplier_s = rs2_data;
                acc_s    = '0;
                cnt_s    = '0;
                state_s  = ST_MUL;
            end else begin
                cnt_s    = cnt_r;
            end
`endif
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_IDLE;
`ifdef EXEC_MUL_EN
                ST_MUL: begin
                    acc_s    = acc_step_s;
                    mcand_s  = mcand_r << 1;
                    mplier_s = mplier_r >> 1;
                    cnt_s    = cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        out_data_s = acc_step_s;
                        state_s    = ST_DONE;
                    end else begin
                        state_s    = ST_MUL;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            out_rd_r      <= 5'd0;
            out_data_r    <= '0;
            out_we_r      <= 1'b0;
            out_illegal_r <= 1'b0;
`ifdef EXEC_MUL_EN
            mcand_r       <= '0;
            mplier_r      <= '0;
            acc_r         <= '0;
            cnt_r         <= '0;
`endif
        end else begin
            state_r       <= state_s;
            out_rd_r      <= out_rd_s;
            out_data_r    <= out_data_s;
            out_we_r      <= out_we_s;
            out_illegal_r <= out_illegal_s;
`ifdef EXEC_MUL_EN
            mcand_r       <= mcand_s;
            mplier_r      <= mplier_s;
            acc_r         <= acc_s;
            cnt_r         <= cnt_s;
`endif
        end
    end

endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage for the simple RISC-V core, downstream of instruction-register decode and register-file read. It accepts a 32-bit R-type instruction with its rs1/rs2 operand values and computes the result: single-cycle ALU operations, plus an optional iterative multiply. It presents the result as a register-file write request (rd, data, write enable) held until the write-back side accepts it.

## Interface
- WIDTH, 32: data width of operands and result; shift amount uses the low $clog2(WIDTH) bits of rs2_data.

- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction and operands are valid
- in_ready  out  1  stage can accept; transfer occurs on an edge where in_valid && in_ready
- instruction  in  32  raw instruction; decoded fields are opcode[6:0], rd[11:7], func3[14:12], rs1[19:15], rs2[24:20], func7[31:25]
- rs1_data  in  WIDTH  value of register rs1
- rs2_data  in  WIDTH  value of register rs2
- out_valid  out  1  result is valid; held until accepted
- out_ready  in  1  write-back side accepts on an edge where out_valid && out_ready
- out_rd  out  5  destination register
- out_data  out  WIDTH  result
- out_we  out  1  register write enable; 0 for rd==0 or illegal
- out_illegal  out  1  instruction not supported
- busy  out  1  high when state != IDLE

## Operation
- Legal only when opcode==7'b0110011. func3/func7 combinations:
  - 000/0000000 ADD; 000/0100000 SUB
  - 001/0000000 SLL; 010/0000000 SLT (signed); 011/0000000 SLTU
  - 100/0000000 XOR; 101/0000000 SRL; 101/0100000 SRA
  - 110/0000000 OR; 111/0000000 AND
  - 000/0000001 MUL (macro only)
- Arithmetic is modulo 2^WIDTH with no overflow flag. SLT/SLTU return 1 or 0, zero-extended. MUL returns the low WIDTH bits of the product.
- Illegal instruction: out_valid=1, out_illegal=1, out_we=0, out_data=0. out_rd still carries instruction[11:7].
- rd==0 on a legal instruction: out_we=0. out_data still holds the computed value.
- FSM states: IDLE, MUL, DONE.
  - IDLE: on accept of a non-MUL instruction, register the result and go to DONE. On accept of MUL, load the operands, clear the accumulator and the count, and go to MUL.
  - MUL: each edge, add the multiplicand to the accumulator if multiplier bit 0 is set, then shift the multiplicand left and the multiplier right, and increment the count. On the edge that processes the WIDTH-th bit, write the result and go to DONE.
  - DONE: out_valid=1. On out_ready, either accept a new instruction in the same edge (same rules as IDLE) or go to IDLE.
- in_ready = !reset && (state==IDLE || (state==DONE && out_ready)). It is combinational from the state and out_ready.
- out_rd, out_data, out_we and out_illegal stay stable while out_valid && !out_ready.

## Timing
- Reset (synchronous): state=IDLE; out_valid, out_we, out_illegal, busy, out_rd and out_data all 0. in_ready=0 while reset is high.
- Reset mid-MUL or in DONE: the operation is dropped with no output. The stage is IDLE on the next cycle.
- Non-MUL latency: out_valid is high in the cycle after the accept edge. Throughput is one instruction per cycle when out_ready is held high.
- MUL latency: WIDTH cycles in MUL, then DONE. out_valid rises WIDTH+1 cycles after the accept edge (33 for WIDTH=32). in_ready=0 throughout MUL.
- Simultaneous accept of the output and accept of the input in DONE: the new result replaces the old on the same edge, and out_valid stays high.
- Inputs are sampled only on the accept edge. Changes to instruction or operands at other times have no effect.

## Configuration
- EXEC_MUL_EN defined: the MUL state and multiplier datapath are built, and func3/func7 000/0000001 is legal.
- EXEC_MUL_EN undefined: no MUL state or datapath. 000/0000001 is illegal and completes in one cycle like any other illegal instruction; busy is never high for it.

## Test plan
- ADD rd=3, rs1_data=5, rs2_data=7, out_ready=1 -> next cycle out_valid=1, out_rd=3, out_data=12, out_we=1. Back-to-back SUB 0-1 -> out_data=0xFFFFFFFF on the following cycle.
- SLT and SLTU with rs1_data=0xFFFFFFFF, rs2_data=1 -> 1 and 0 respectively. SRA with 0x80000000 and rs2_data=36 -> 0xF8000000. SRL with the same inputs -> 0x08000000.
- MUL 6*7 (macro on) -> in_ready=0 and busy=1 for 32 cycles, then out_data=42 at accept+33. Macro off -> out_illegal=1, out_we=0 at accept+1.
- Hold out_ready=0 for 3 cycles after ADD -> outputs stable and in_ready=0. Raise out_ready with in_valid=1 -> the old result is retired and the new one is accepted on the same edge.
- ADD with rd=0 -> out_we=0, out_data=sum. opcode=0010011 -> out_illegal=1, out_data=0.
- reset=1 mid-MUL (cycle 10) -> next cycle state IDLE, out_valid=0, busy=0. No result ever appears for the aborted MUL.
